// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the RV32I multi-cycle sequencer.
//   - RV32I major opcode constants (ir[6:0])
//   - EBREAK_WORD, the one SYSTEM encoding that stops the sequencer
//   - instr_class_e, the coarse instruction class used by the sequencer
//   - seq_state_e, the sequencer state encoding
//   - opcode_class(), maps a major opcode to its class
package core_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] EBREAK_WORD = 32'h00100073;

   typedef enum logic [2:0] {
      CLS_ILLEGAL,
      CLS_LOAD,
      CLS_STORE,
      CLS_ALU,      // OP, OP-IMM, LUI, AUIPC
      CLS_BRANCH,
      CLS_JUMP,     // JAL, JALR
      CLS_SYSTEM
   } instr_class_e;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_MEM,
      ST_WRITEBACK,
      ST_HALT
   } seq_state_e;

   function automatic instr_class_e opcode_class(input logic [6:0] opcode);
      instr_class_e cls;
      case (opcode)
         OPC_LOAD:   cls = CLS_LOAD;
         OPC_STORE:  cls = CLS_STORE;
         OPC_OP_IMM,
         OPC_OP,
         OPC_LUI,
         OPC_AUIPC:  cls = CLS_ALU;
         OPC_BRANCH: cls = CLS_BRANCH;
         OPC_JAL,
         OPC_JALR:   cls = CLS_JUMP;
         OPC_SYSTEM: cls = CLS_SYSTEM;
         default:    cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: purely combinational decode of the instruction register
// into the few attributes the sequencer needs.
//   ir        in  32  instruction register
//   legal     out  1  major opcode is a supported RV32I class
//   writes_rd out  1  class writes rd and rd is not x0
//   is_mem    out  1  LOAD or STORE
//   is_store  out  1  STORE
//   is_ebreak out  1  exact EBREAK encoding
module opcode_classifier
   import core_pkg::*;
(
   input  logic [31:0] ir,
   output logic        legal,
   output logic        writes_rd,
   output logic        is_mem,
   output logic        is_store,
   output logic        is_ebreak
);

   instr_class_e cls;

   always_comb begin
      cls       = opcode_class(ir[6:0]);
      legal     = (cls != CLS_ILLEGAL);
      // Writes to x0 are suppressed here so the sequencer never strobes rd=0.
      writes_rd = ((cls == CLS_LOAD) || (cls == CLS_ALU) || (cls == CLS_JUMP))
                  && (ir[11:7] != 5'd0);
      is_mem    = (cls == CLS_LOAD) || (cls == CLS_STORE);
      is_store  = (cls == CLS_STORE);
      is_ebreak = (ir == EBREAK_WORD);
   end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control sequencer for the RV32I core.
// Fetches through a request/valid imem handshake into an instruction register,
// then steps DECODE -> EXECUTE -> (MEM) -> WRITEBACK, issuing PC and regfile
// write enables. EBREAK or an unrecognised opcode parks the sequencer in HALT
// until reset.
//   clk, rst           clock; asynchronous active-high reset
//   imem_req           out  fetch request (FETCH state)
//   imem_rvalid/rdata  in   fetch completion and instruction word
//   ir                 out  instruction register
//   dmem_req/dmem_we   out  data access request, 1 = store (MEM state)
//   dmem_rvalid        in   data access completion
//   pc_write_enable    out  advance PC (WRITEBACK)
//   reg_write_enable   out  write rd (WRITEBACK, rd-writing classes, rd != 0)
//   reg_write_sel      out  0 = ALU result, 1 = load data
//   ebreak_pulse       out  one-cycle strobe in DECODE of EBREAK
//   illegal, halted    out  sticky status flags
//   instret            out  retired-instruction counter (wraps)
module core_sequencer
   import core_pkg::*;
#(
   parameter int          INSTRET_WIDTH = 32,
   parameter logic [31:0] NOP_WORD      = 32'h00000013
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   input  logic                     imem_rvalid,
   input  logic [31:0]              imem_rdata,
   output logic [31:0]              ir,
   output logic                     dmem_req,
   output logic                     dmem_we,
   input  logic                     dmem_rvalid,
   output logic                     pc_write_enable,
   output logic                     reg_write_enable,
   output logic                     reg_write_sel,
   output logic                     ebreak_pulse,
   output logic                     illegal,
   output logic                     halted,
   output logic [INSTRET_WIDTH-1:0] instret
);

   seq_state_e               state_reg, state_next;
   logic [31:0]              ir_reg;
   logic [INSTRET_WIDTH-1:0] instret_reg;
   logic                     illegal_reg;
   logic                     halted_reg;

   logic legal, writes_rd, is_mem, is_store, is_ebreak;

   opcode_classifier u_classifier (
      .ir        (ir_reg),
      .legal     (legal),
      .writes_rd (writes_rd),
      .is_mem    (is_mem),
      .is_store  (is_store),
      .is_ebreak (is_ebreak)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_BOOT;
         ir_reg      <= NOP_WORD;
         instret_reg <= '0;
         illegal_reg <= 1'b0;
         halted_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_FETCH && imem_rvalid)
            ir_reg <= imem_rdata;
         // EBREAK is checked first, so it is never flagged illegal.
         if (state_reg == ST_DECODE && !is_ebreak && !legal)
            illegal_reg <= 1'b1;
         if (state_next == ST_HALT)
            halted_reg <= 1'b1;
         if (state_reg == ST_WRITEBACK)
            instret_reg <= instret_reg + INSTRET_WIDTH'(1);
      end
   end

   // Next state plus Moore-decoded strobes; inputs only steer state_next.
   always_comb begin
      state_next       = state_reg;
      imem_req         = 1'b0;
      dmem_req         = 1'b0;
      dmem_we          = 1'b0;
      pc_write_enable  = 1'b0;
      reg_write_enable = 1'b0;
      reg_write_sel    = 1'b0;
      ebreak_pulse     = 1'b0;
      case (state_reg)
         ST_BOOT: state_next = ST_FETCH;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_rvalid)
               state_next = ST_DECODE;
         end
         ST_DECODE: begin
            if (is_ebreak) begin
               ebreak_pulse = 1'b1;
               state_next   = ST_HALT;
            end else if (!legal) begin
               state_next = ST_HALT;
            end else begin
               state_next = ST_EXECUTE;
            end
         end
         ST_EXECUTE: state_next = is_mem ? ST_MEM : ST_WRITEBACK;
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (dmem_rvalid)
               state_next = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            pc_write_enable  = 1'b1;
            reg_write_enable = writes_rd;
            reg_write_sel    = is_mem && !is_store;
            state_next       = ST_FETCH;
         end
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_HALT;
      endcase
   end

   assign ir      = ir_reg;
   assign instret = instret_reg;
   assign illegal = illegal_reg;
   assign halted  = halted_reg;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

   localparam logic [31:0] NOP        = 32'h00000013;
   localparam logic [31:0] I_ADDI_X1  = 32'h00500093;
   localparam logic [31:0] I_LW_X2    = 32'h00002103;
   localparam logic [31:0] I_SW_X1    = 32'h00102023;
   localparam logic [31:0] I_BEQ      = 32'h00000063;
   localparam logic [31:0] I_ECALL    = 32'h00000073;
   localparam logic [31:0] I_LUI_X5   = 32'h000012B7;
   localparam logic [31:0] I_EBREAK   = 32'h00100073;
   localparam logic [31:0] I_BAD      = 32'hFFFFFFFF;
   localparam logic [31:0] I_ADDI_X3  = 32'h00300193;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] ir;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_rvalid = 1'b0;
   logic        pc_write_enable;
   logic        reg_write_enable;
   logic        reg_write_sel;
   logic        ebreak_pulse;
   logic        illegal;
   logic        halted;
   logic [31:0] instret;

   core_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req         (imem_req),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .ir               (ir),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_rvalid      (dmem_rvalid),
      .pc_write_enable  (pc_write_enable),
      .reg_write_enable (reg_write_enable),
      .reg_write_sel    (reg_write_sel),
      .ebreak_pulse     (ebreak_pulse),
      .illegal          (illegal),
      .halted           (halted),
      .instret          (instret)
   );

   always #5 clk = ~clk;

   // Expected events: kind 0 = WRITEBACK, kind 1 = EBREAK strobe.
   typedef struct {
      int          kind;
      logic        rwe;
      logic        rsel;
      logic [31:0] instret;
      int          lat;
      int          abs_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   fetch_start = 0;
   logic prev_req = 1'b0;
   logic [31:0] exp_instret = 0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Cycle 1 is the first cycle after rst is released.
   always @(posedge clk) begin
      if (rst) cyc = 1;
      else     cyc = cyc + 1;
   end

   // Monitor: pops an expectation whenever the DUT shows a WRITEBACK or EBREAK.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_req = 1'b0;
      end else begin
         if (imem_req && !prev_req) fetch_start = cyc;
         prev_req = imem_req;
         if (pc_write_enable || ebreak_pulse) begin
            if (sb.size() == 0) begin
               check("unexpected_event", {62'd0, pc_write_enable, ebreak_pulse}, 64'd0);
            end else begin
               e = sb.pop_front();
               check("event_kind", {63'd0, ebreak_pulse}, 64'(e.kind));
               check("event_instret", {32'd0, instret}, {32'd0, e.instret});
               if (e.kind == 0) begin
                  $display("WB  ir=%08h rwe=%0b rsel=%0b instret=%0d lat=%0d cyc=%0d",
                           ir, reg_write_enable, reg_write_sel, instret,
                           cyc - fetch_start + 1, cyc);
                  check("wb_reg_write_enable", {63'd0, reg_write_enable}, {63'd0, e.rwe});
                  check("wb_reg_write_sel", {63'd0, reg_write_sel}, {63'd0, e.rsel});
                  check("wb_latency", 64'(cyc - fetch_start + 1), 64'(e.lat));
                  if (e.abs_cyc != 0)
                     check("wb_abs_cycle", 64'(cyc), 64'(e.abs_cyc));
               end else begin
                  $display("EBREAK strobe ir=%08h instret=%0d cyc=%0d", ir, instret, cyc);
               end
            end
         end
      end
   end

   task automatic push_wb(input logic rwe, input logic rsel, input int lat, input int abs_c);
      exp_t e;
      e.kind = 0; e.rwe = rwe; e.rsel = rsel; e.instret = exp_instret;
      e.lat = lat; e.abs_cyc = abs_c;
      sb.push_back(e);
      exp_instret = exp_instret + 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_rvalid = 1'b0;
      dmem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_imem_req", {63'd0, imem_req}, 64'd0);
      check("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
      check("rst_enables", {61'd0, pc_write_enable, reg_write_enable, ebreak_pulse}, 64'd0);
      check("rst_ir", {32'd0, ir}, {32'd0, NOP});
      check("rst_flags", {62'd0, illegal, halted}, 64'd0);
      check("rst_instret", {32'd0, instret}, 64'd0);
      rst = 1'b0;
      exp_instret = 0;
   endtask

   // Called at a negedge; returns at the negedge of the DECODE cycle.
   task automatic do_fetch(input logic [31:0] w, input int wt);
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!imem_req) begin
         check("fetch_timeout", 64'd0, 64'd1);
         return;
      end
      repeat (wt) @(negedge clk);
      imem_rvalid = 1'b1;
      imem_rdata  = w;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEADBEEF;
      check("decode_ir", {32'd0, ir}, {32'd0, w});
   endtask

   task automatic do_mem(input int wt, input logic we_exp, input logic rwe, input int lat);
      int n = 0;
      int held = 0;
      while (!dmem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!dmem_req) begin
         check("mem_timeout", 64'd0, 64'd1);
         return;
      end
      check("dmem_we", {63'd0, dmem_we}, {63'd0, we_exp});
      for (int i = 0; i <= wt; i++) begin
         if (dmem_req) held++;
         if (i == wt) begin
            push_wb(rwe, !we_exp, lat, 0);
            dmem_rvalid = 1'b1;
         end
         @(negedge clk);
      end
      dmem_rvalid = 1'b0;
      $display("MEM we=%0b req_cycles=%0d", we_exp, held);
      check("dmem_req_cycles", 64'(held), 64'(wt + 1));
      check("dmem_req_dropped", {63'd0, dmem_req}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      @(negedge clk);
      do_reset();
      // cycle 1 after release is BOOT
      check("boot_no_req", {63'd0, imem_req}, 64'd0);
      @(negedge clk);
      check("first_req_cycle", 64'(cyc), 64'd2);
      check("first_req", {63'd0, imem_req}, 64'd1);

      push_wb(1'b1, 1'b0, 4, 5);
      do_fetch(I_ADDI_X1, 0);
      do_fetch(I_LW_X2, 0);
      do_mem(3, 1'b0, 1'b1, 8);
      do_fetch(I_SW_X1, 0);
      do_mem(0, 1'b1, 1'b0, 5);
      push_wb(1'b0, 1'b0, 6, 0);
      do_fetch(I_BEQ, 2);
      push_wb(1'b0, 1'b0, 4, 0);
      do_fetch(NOP, 0);
      push_wb(1'b0, 1'b0, 4, 0);
      do_fetch(I_ECALL, 0);
      push_wb(1'b1, 1'b0, 4, 0);
      do_fetch(I_LUI_X5, 0);

      // EBREAK: strobe in DECODE, halted the following cycle, nothing after.
      e.kind = 1; e.rwe = 0; e.rsel = 0; e.instret = exp_instret; e.lat = 0; e.abs_cyc = 0;
      sb.push_back(e);
      do_fetch(I_EBREAK, 0);
      check("ebreak_halted_late", {63'd0, halted}, 64'd0);
      @(negedge clk);
      check("ebreak_halted", {63'd0, halted}, 64'd1);
      check("ebreak_pulse_1cyc", {63'd0, ebreak_pulse}, 64'd0);
      check("ebreak_not_illegal", {63'd0, illegal}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         imem_rvalid = i[0];
         @(negedge clk);
         check("halt_no_req", {63'd0, imem_req}, 64'd0);
      end
      imem_rvalid = 1'b0;
      check("ebreak_instret", {32'd0, instret}, {32'd0, exp_instret});

      // Illegal opcode, then stray responses while halted.
      @(negedge clk);
      do_reset();
      do_fetch(I_BAD, 0);
      check("illegal_late", {62'd0, illegal, halted}, 64'd0);
      @(negedge clk);
      check("illegal_flags", {62'd0, illegal, halted}, 64'd3);
      for (int i = 0; i < 4; i++) begin
         imem_rvalid = 1'b1;
         dmem_rvalid = 1'b1;
         imem_rdata  = 32'h00000013;
         @(negedge clk);
         check("illegal_quiet",
               {60'd0, imem_req, dmem_req, pc_write_enable, reg_write_enable}, 64'd0);
      end
      imem_rvalid = 1'b0;
      dmem_rvalid = 1'b0;
      check("illegal_ir_kept", {32'd0, ir}, {32'd0, I_BAD});
      check("illegal_instret", {32'd0, instret}, 64'd0);

      // Reset in the middle of a load's MEM wait.
      @(negedge clk);
      do_reset();
      push_wb(1'b1, 1'b0, 4, 5);
      do_fetch(I_ADDI_X1, 0);
      do_fetch(I_LW_X2, 0);
      begin
         int n = 0;
         while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      check("midmem_req_seen", {63'd0, dmem_req}, 64'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midmem_rst_dmem_req", {63'd0, dmem_req}, 64'd0);
      check("midmem_rst_ir", {32'd0, ir}, {32'd0, NOP});
      check("midmem_rst_instret", {32'd0, instret}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_instret = 0;
      @(negedge clk);
      // Cycle 2: stale dmem response arrives alongside the new fetch.
      check("midmem_refetch_cycle", 64'(cyc), 64'd2);
      check("midmem_refetch_req", {62'd0, imem_req, dmem_req}, 64'd2);
      push_wb(1'b1, 1'b0, 4, 5);
      dmem_rvalid = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = I_ADDI_X3;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      imem_rvalid = 1'b0;
      check("midmem_ir", {32'd0, ir}, {32'd0, I_ADDI_X3});
      repeat (4) @(negedge clk);
      check("midmem_instret", {32'd0, instret}, 64'd1);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32I processor core. Fetches each instruction through a request/valid instruction-memory handshake and latches it into an internal instruction register. It then steps the datapath through decode, execute, optional memory access and writeback, issuing the PC and register-file write enables. It sits between the instruction/data memory ports and the existing program counter, regfile, ALU and control logic, and replaces their free-running single-cycle sequencing.

## Interface
- INSTRET_WIDTH, 32, width of retired-instruction counter
- NOP_WORD, 32'h00000013, instruction register value after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_rvalid  in  1  fetch data valid, completes request
- imem_rdata  in  32  fetched instruction word
- ir  out  32  instruction register, feeds decode/regfile/ALU
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_rvalid  in  1  data access complete (load data or store ack)
- pc_write_enable  out  1  advance/update PC this edge
- reg_write_enable  out  1  write rd this edge
- reg_write_sel  out  1  0 = ALU result, 1 = load data
- ebreak_pulse  out  1  one-cycle strobe on EBREAK decode
- illegal  out  1  sticky, unrecognised opcode decoded
- halted  out  1  sticky, sequencer stopped
- instret  out  INSTRET_WIDTH  retired-instruction count

## Operation
- States: BOOT, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- BOOT: entered on reset; unconditionally goes to FETCH the next cycle.
- FETCH: imem_req=1, held until imem_rvalid. On imem_rvalid, ir <= imem_rdata and go to DECODE.
- DECODE (1 cycle):
  - ir == 32'h00100073: ebreak_pulse=1, go to HALT.
  - Opcode not one of {LOAD, STORE, OP-IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM}: illegal<=1, go to HALT.
  - Otherwise go to EXECUTE.
  - SYSTEM other than EBREAK executes as NOP.
- EXECUTE (1 cycle): LOAD/STORE go to MEM; all others go to WRITEBACK.
- MEM: dmem_req=1, dmem_we=1 for STORE, held until dmem_rvalid, then go to WRITEBACK.
- WRITEBACK (1 cycle):
  - pc_write_enable=1, instret+1.
  - reg_write_enable=1 only for classes that write rd (not STORE, BRANCH, SYSTEM) and only when rd != 0.
  - reg_write_sel=1 only for LOAD.
  - Then go to FETCH.
- HALT: halted=1, all enables and requests 0. Leaves only on rst.
- imem_rvalid outside FETCH and dmem_rvalid outside MEM are ignored.
- instret wraps modulo 2^INSTRET_WIDTH; EBREAK and illegal instructions are not counted.

## Timing
- All outputs except ir, illegal, halted and instret are Moore-decoded from state (and ir class). No input-to-output combinational path.
- Reset values:
  - state BOOT, ir=NOP_WORD, instret=0, illegal=0, halted=0.
  - All request, enable and strobe outputs 0.
- Async rst mid-FETCH or mid-MEM drops imem_req/dmem_req immediately. An in-flight response is discarded.
- A valid arriving in the same cycle the request is first raised completes the request.
- Latency with zero-wait memories: ALU/branch/jump 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK); load/store 5 cycles. Each memory wait cycle adds 1.
- First imem_req is asserted in the second cycle after rst deasserts.
- ebreak_pulse is high for exactly one cycle (the DECODE cycle). halted rises the following cycle.

## Structure
- Shared package core_pkg holds:
  - RV32I opcode constants.
  - EBREAK_WORD = 32'h00100073.
  - Instruction class encoding.
  - Sequencer state enum.
- Sub-module opcode_classifier (combinational): maps ir to {legal, writes_rd, is_mem, is_store, is_ebreak}.
- FSM, instruction register and instret counter live in core_sequencer.

## Test plan
- addi x1,x0,5 (32'h00500093), zero-wait imem -> imem_req at cycle 2; WRITEBACK at cycle 5 with reg_write_enable=1, reg_write_sel=0, pc_write_enable=1; instret=1.
- lw x2,0(x0) (32'h00002103), dmem_rvalid delayed 3 cycles -> dmem_req=1, dmem_we=0 held 4 cycles; then reg_write_enable=1, reg_write_sel=1.
- sw x1,0(x0) (32'h00102023) -> dmem_we=1 during MEM; WRITEBACK with reg_write_enable=0, pc_write_enable=1.
- 32'h00100073 fetched -> ebreak_pulse for 1 cycle, halted=1 thereafter; no further imem_req; instret unchanged.
- 32'hFFFFFFFF fetched -> illegal=1 and halted=1; stray imem_rvalid/dmem_rvalid pulses produce no activity.
- rst asserted mid-MEM with dmem_rvalid arriving 1 cycle after release -> outputs 0 immediately, ir=NOP_WORD, response ignored, new FETCH begins 2 cycles after release.
